// File: rtl/key_switch_in_pkg.sv
// Shared constants for the key/switch input peripheral: register offsets,
// IRQ status bit positions and the default debounce hold time.
package key_switch_in_pkg;

  localparam logic [15:0] DEB_CYCLES_DEFAULT = 16'd50000;

  localparam int unsigned SW_WIDTH  = 64;
  localparam int unsigned KEY_WIDTH = 8;

  typedef enum logic [2:0] {
    OFF_SW_LO = 3'd0,
    OFF_SW_HI = 3'd1,
    OFF_KEY   = 3'd2,
    OFF_IRQ   = 3'd3
  } reg_off_e;

  localparam int unsigned IRQ_PEND_BIT = 0;
  localparam int unsigned IRQ_EN_BIT   = 1;

  function automatic logic [31:0] irq_status(input logic en, input logic pend);
    logic [31:0] r;
    r               = '0;
    r[IRQ_EN_BIT]   = en;
    r[IRQ_PEND_BIT] = pend;
    return r;
  endfunction

endpackage

// File: rtl/key_switch_in_input_debounce.sv
// Vector debouncer: 2-flop synchronizer on active-low pins, then a single
// shared hold counter that restarts whenever any bit of the vector moves.
module input_debounce
  import key_switch_in_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_n,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] synced;

  always_comb begin
    sync1_d   = pin_n;
    sync2_d   = sync1_q;
    synced    = ~sync2_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (synced != cand_q) begin
      cand_d = synced;
      cnt_d  = DEB_CYCLES;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 16'd1;
    end else if (cand_q != stable_q) begin
      stable_d  = cand_q;
      changed_d = 1'b1;
    end
  end

  // Synchronizers reset to the idle (released) pin level so that reset
  // itself never looks like a key or switch edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign stable  = stable_q;
  assign changed = changed_q;

endmodule

// File: rtl/key_switch_in.sv
// Key/DIP-switch bridge peripheral: two debouncers plus a read mux and an
// optional change interrupt built only when KEY_SWITCH_IRQ_EN is defined.
module key_switch_in
  import key_switch_in_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WE,
  input  logic [31:0] WD,
  input  logic [2:0]  innerADDR,
  output logic [31:0] RD,
  input  logic [63:0] dip_switch,
  input  logic [7:0]  user_key,
  output logic        IRQ
);

  logic [SW_WIDTH-1:0]  sw_stable;
  logic [KEY_WIDTH-1:0] key_stable;
  logic                 sw_changed;
  logic                 key_changed;
  logic [31:0]          irq_word;

  input_debounce #(
    .WIDTH      (SW_WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_deb (
    .clk     (CLK),
    .rst     (RST),
    .pin_n   (dip_switch),
    .stable  (sw_stable),
    .changed (sw_changed)
  );

  input_debounce #(
    .WIDTH      (KEY_WIDTH),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_deb (
    .clk     (CLK),
    .rst     (RST),
    .pin_n   (user_key),
    .stable  (key_stable),
    .changed (key_changed)
  );

`ifdef KEY_SWITCH_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_pend_q, irq_pend_d;
  logic irq_wr;
  logic unused_wd;

  assign unused_wd = ^WD[31:2];

  // A change pulse arriving with a W1C clear must not be lost, so the set
  // is applied after the clear.
  always_comb begin
    irq_wr     = WE && (innerADDR == OFF_IRQ);
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (irq_wr) begin
      irq_en_d = WD[IRQ_EN_BIT];
      if (WD[IRQ_PEND_BIT]) irq_pend_d = 1'b0;
    end
    if (sw_changed || key_changed) irq_pend_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_word = irq_status(irq_en_q, irq_pend_q);
  assign IRQ      = irq_pend_q & irq_en_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{WE, WD, sw_changed, key_changed};
  assign irq_word          = '0;
  assign IRQ               = 1'b0;
`endif

  always_comb begin
    RD = '0;
    case (reg_off_e'(innerADDR))
      OFF_SW_LO: RD = sw_stable[31:0];
      OFF_SW_HI: RD = sw_stable[63:32];
      OFF_KEY:   RD = {24'd0, key_stable};
      OFF_IRQ:   RD = irq_word;
      default:   RD = '0;
    endcase
  end

endmodule

// File: tb/tb_key_switch_in.sv
// Self-checking bench for key_switch_in with a short debounce time (4 cycles);
// IRQ expectations follow the KEY_SWITCH_IRQ_EN build option.
module tb_key_switch_in;

`ifdef KEY_SWITCH_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        WE;
  logic [31:0] WD;
  logic [2:0]  innerADDR;
  logic [31:0] RD;
  logic [63:0] dip_switch;
  logic [7:0]  user_key;
  logic        IRQ;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] dip;
    logic [7:0]  key;
    int unsigned hold;
    logic [2:0]  addr;
    logic [31:0] rd;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  key_switch_in #(.DEB_CYCLES(16'd4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WE         (WE),
    .WD         (WD),
    .innerADDR  (innerADDR),
    .RD         (RD),
    .dip_switch (dip_switch),
    .user_key   (user_key),
    .IRQ        (IRQ)
  );

  always #10 CLK = ~CLK;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic void expect_rd(input string name, input logic [2:0] addr,
                                    input logic [31:0] rd, input logic irq);
    exp_t e;
    e.name = name;
    e.addr = addr;
    e.rd   = rd;
    e.irq  = irq;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] exp3(input logic en, input logic pend);
    return IRQ_BUILT ? {30'd0, en, pend} : 32'd0;
  endfunction

  task automatic drain;
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      innerADDR = e.addr;
      #1;
      compared++;
      if (RD !== e.rd || IRQ !== e.irq) begin
        mismatched++;
        $display("FAIL %s: addr=%0d got RD=%h IRQ=%b, expected RD=%h IRQ=%b",
                 e.name, e.addr, RD, IRQ, e.rd, e.irq);
      end
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    WE = 1'b1;
    WD = d;
    innerADDR = a;
    tick(1);
    WE = 1'b0;
    WD = '0;
  endtask

  initial begin
    logic [63:0] glitch;

    vecs[0] = '{"vec_sw_lo_a",  ~64'h1234_5678_9ABC_DEF0, ~8'hA5, 10, 3'd0, 32'h9ABC_DEF0};
    vecs[1] = '{"vec_sw_hi_a",  ~64'h1234_5678_9ABC_DEF0, ~8'hA5,  0, 3'd1, 32'h1234_5678};
    vecs[2] = '{"vec_key_a",    ~64'h1234_5678_9ABC_DEF0, ~8'hA5,  0, 3'd2, 32'h0000_00A5};
    vecs[3] = '{"vec_off6_a",   ~64'h1234_5678_9ABC_DEF0, ~8'hA5,  0, 3'd6, 32'h0};
    vecs[4] = '{"vec_sw_lo_b",  ~64'h8000_0000_0000_0001, ~8'h80, 10, 3'd0, 32'h0000_0001};
    vecs[5] = '{"vec_sw_hi_b",  ~64'h8000_0000_0000_0001, ~8'h80,  0, 3'd1, 32'h8000_0000};
    vecs[6] = '{"vec_key_b",    ~64'h8000_0000_0000_0001, ~8'h80,  0, 3'd2, 32'h0000_0080};
    vecs[7] = '{"vec_irq_b",    ~64'h8000_0000_0000_0001, ~8'h80,  0, 3'd3, exp3(1'b0, 1'b1)};

    RST = 1'b1; WE = 1'b0; WD = '0; innerADDR = '0;
    dip_switch = '1; user_key = '1;
    tick(3);
    RST = 1'b0;
    for (int a = 0; a < 8; a++) expect_rd("reset_rd", 3'(a), 32'd0, 1'b0);
    drain();

    // Key press latency: stable visible on the 8th edge, not the 7th.
    user_key = 8'hFE;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      expect_rd("key_latency", 3'd2, (k >= 8) ? 32'd1 : 32'd0, 1'b0);
      drain();
    end
    tick(2);
    expect_rd("key_pend_set", 3'd3, exp3(1'b0, 1'b1), 1'b0);
    drain();
    write_reg(3'd3, 32'h1);
    expect_rd("key_pend_clr", 3'd3, exp3(1'b0, 1'b0), 1'b0);
    drain();

    // Short glitch on dip_switch[40] must be filtered.
    glitch = '1;
    glitch[40] = 1'b0;
    dip_switch = glitch;
    tick(3);
    dip_switch = '1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      expect_rd("glitch_sw_hi", 3'd1, 32'd0, 1'b0);
      drain();
    end
    expect_rd("glitch_no_pend", 3'd3, exp3(1'b0, 1'b0), 1'b0);
    drain();

    // Switch change with IRQ enabled.
    write_reg(3'd3, 32'h2);
    dip_switch = 64'hFFFF_FFFF_FFFF_FF00;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      expect_rd("sw_irq", 3'd0, (k >= 8) ? 32'hFF : 32'd0,
                (k >= 9) ? IRQ_BUILT : 1'b0);
      drain();
    end
    write_reg(3'd3, 32'h3);
    expect_rd("sw_irq_clr", 3'd3, exp3(1'b1, 1'b0), 1'b0);
    drain();

    // W1C landing in the same cycle as a key change pulse.
    user_key = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      expect_rd("key_release", 3'd2, (k >= 8) ? 32'd0 : 32'd1, 1'b0);
      drain();
    end
    write_reg(3'd3, 32'h3);
    expect_rd("w1c_collide", 3'd3, exp3(1'b1, 1'b1), IRQ_BUILT);
    drain();
    write_reg(3'd3, 32'h3);
    expect_rd("w1c_plain", 3'd3, exp3(1'b1, 1'b0), 1'b0);
    drain();

    // Reset while a key press is two counts from committing.
    user_key = 8'hFE;
    tick(5);
    RST = 1'b1;
    user_key = 8'hFF;
    dip_switch = '1;
    tick(1);
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      expect_rd("rst_mid_key", 3'd2, 32'd0, 1'b0);
      expect_rd("rst_mid_irq", 3'd3, 32'd0, 1'b0);
      expect_rd("rst_mid_sw",  3'd0, 32'd0, 1'b0);
      drain();
    end

    for (int i = 0; i < 8; i++) begin
      dip_switch = vecs[i].dip;
      user_key   = vecs[i].key;
      tick(vecs[i].hold);
      expect_rd(vecs[i].name, vecs[i].addr, vecs[i].rd, 1'b0);
      drain();
    end

    write_reg(3'd0, 32'hDEAD_BEEF);
    write_reg(3'd2, 32'hDEAD_BEEF);
    write_reg(3'd5, 32'hDEAD_BEEF);
    expect_rd("ro_off0", 3'd0, 32'h1, 1'b0);
    expect_rd("ro_off2", 3'd2, 32'h80, 1'b0);
    expect_rd("ro_off5", 3'd5, 32'h0, 1'b0);
    drain();
    write_reg(3'd3, 32'h1);
    expect_rd("final_clr", 3'd3, 32'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_switch_in.md
KEY_SWITCH_IN -- requirements
Module: key_switch_in

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16'd50000: debounce hold time in CLK cycles, legal 1..65535.
REQ-002 SHALL have port CLK, input, 1: single system clock; all state on posedge.
REQ-003 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port WE, input, 1: bridge write strobe.
REQ-005 SHALL have port WD, input, 32: bridge write data.
REQ-006 SHALL have port innerADDR, input, 3: word offset within device.
REQ-007 SHALL have port RD, output, 32: read data, combinational from innerADDR.
REQ-008 SHALL have port dip_switch, input, 64: board DIP switches, active-low, asynchronous.
REQ-009 SHALL have port user_key, input, 8: board push keys, active-low, asynchronous.
REQ-010 SHALL have port IRQ, output, 1: level interrupt to CPU.

Function
REQ-011 SHALL pass each raw input bit through a 2-flop synchronizer, then invert, so internal 1 = switch on / key pressed.
REQ-012 SHALL debounce switches (64 bit) and keys (8 bit) as two independent vector debouncers, each holding cand, cnt (16 bit), stable.
REQ-013 SHALL, when synced vector != cand, load cand <= synced and cnt <= DEB_CYCLES.
REQ-014 SHALL, when synced == cand and cnt != 0, decrement cnt by 1.
REQ-015 SHALL, when cnt == 0 and cand != stable, set stable <= cand and pulse changed for exactly one cycle.
REQ-016 SHALL thus update stable on the (DEB_CYCLES+4)th posedge after the first edge sampling a steady new pin value; any glitch before that restarts the count.
REQ-017 SHALL map RD: offset 0 = sw_stable[31:0]; 1 = sw_stable[63:32]; 2 = {24'd0, key_stable}; 3 = {30'd0, irq_en, irq_pend}; 4..7 = 32'd0.
REQ-018 SHALL ignore writes to offsets 0,1,2,4..7.
REQ-019 SHALL, on WE at offset 3, load irq_en <= WD[1] and clear irq_pend when WD[0]=1 (write-1-to-clear).
REQ-020 SHALL set irq_pend on any changed pulse from either debouncer; a set in the same cycle as a W1C clear wins.
REQ-021 SHALL drive IRQ = irq_pend & irq_en, combinational from registers.
REQ-022 SHALL not narrow or wrap cnt; it saturates at 0.

Reset
REQ-023 SHALL on RST set synchronizer flops to all-ones (inactive pin level), cand = stable = 0, cnt = 0, irq_pend = 0, irq_en = 0.
REQ-024 SHALL therefore output IRQ = 0 and RD = 0 at every offset in the cycle after reset.
REQ-025 SHALL on RST mid-count discard cand/cnt; no changed pulse is generated by the reset itself.

Configuration
REQ-026 SHALL with KEY_SWITCH_IRQ_EN defined implement irq_pend, irq_en, offset 3, and IRQ per REQ-019..021.
REQ-027 SHALL without KEY_SWITCH_IRQ_EN tie IRQ to 0, read offset 3 as 32'd0, ignore all writes, and synthesize no IRQ registers.

Structure
REQ-028 SHALL keep register offsets (0..3), status bit positions and DEB_CYCLES default in the shared peripheral constants package.
REQ-029 SHALL implement one sub-module input_debounce (parameters WIDTH, DEB_CYCLES; synchronizer + REQ-013..015), instantiated twice (WIDTH 64, 8).

Verification (DEB_CYCLES=4)
REQ-030 SHALL check: reset, pins all-ones -> RD=0 at offsets 0..7, IRQ=0.
REQ-031 SHALL check: user_key=8'hFE held steady -> offset 2 reads 32'h01 exactly 8 edges after first sample, not 7.
REQ-032 SHALL check: dip_switch[40] low for 3 cycles then back high -> offset 1 stays 0, no changed pulse.
REQ-033 SHALL check: write 32'h2 to offset 3, then dip_switch=64'hFFFF_FFFF_FFFF_FF00 -> offset 0 reads 32'hFF, IRQ=1 from next cycle; write 32'h3 -> IRQ=0.
REQ-034 SHALL check: W1C write to offset 3 in same cycle as a key changed pulse -> irq_pend stays 1.
REQ-035 SHALL check: RST asserted with cnt=2 pending key press -> stable stays 0, IRQ=0; with KEY_SWITCH_IRQ_EN undefined offset 3 reads 0 and IRQ never rises.
